// File: rtl/ifu_axi_fetch.sv
// ifu_axi_fetch: instruction fetch unit with a single-outstanding AXI-lite read
// master. After reset release it fetches RESET_PC on its own, then fetches
// whatever PC the writeback/PC logic requests. It hands each instruction to
// decode through a valid/ready pair.
// Optional feature: define IFU_PERF_CNT_EN to add the fetch_cnt output.
// fetch_cnt counts accepted decode handshakes.
module ifu_axi_fetch #(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = 32'h8000_0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   input  logic [ADDR_W-1:0] req_pc,
   output logic              arvalid,
   output logic [ADDR_W-1:0] araddr,
   input  logic              arready,
   input  logic              rvalid,
   input  logic [31:0]       rdata,
   input  logic [1:0]        rresp,
   output logic              rready,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_inst,
   output logic [ADDR_W-1:0] out_pc,
`ifdef IFU_PERF_CNT_EN
   output logic [31:0]       fetch_cnt,
`endif
   output logic              out_err
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] ADDR = 2'd1;
   localparam logic [1:0] DATA = 2'd2;
   localparam logic [1:0] HOLD = 2'd3;

   logic [1:0]        state;
   logic [ADDR_W-1:0] pcReg;
   logic [31:0]       instReg;
   logic              errReg;
   logic              bootPending;
   logic              launch;
   logic [ADDR_W-1:0] nextPc;
   logic              handshake;

   // Bus and decode strobes come straight from the state, so an asynchronous
   // reset drops them immediately.
   assign arvalid   = (state == ADDR);
   assign rready    = (state == DATA);
   assign out_valid = (state == HOLD);
   assign araddr    = pcReg;
   assign out_pc    = pcReg;
   assign out_inst  = instReg;
   assign out_err   = errReg;
   assign handshake = out_valid && out_ready;

   // Decide when a new fetch starts and which PC it uses. The boot fetch wins
   // over a request. A request is only honoured from IDLE or while the held
   // instruction is being accepted.
   always_comb begin
      launch = 1'b0;
      nextPc = req_pc;
      if (state == IDLE) begin
         if (bootPending) begin
            launch = 1'b1;
            nextPc = RESET_PC;
         end else if (req_valid) begin
            launch = 1'b1;
         end
      end else if (state == HOLD) begin
         launch = handshake && req_valid;
      end
   end

   // Fetch state machine. A misaligned PC never reaches the bus. It goes
   // straight to HOLD as a faulting, zero instruction.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         pcReg       <= RESET_PC;
         instReg     <= '0;
         errReg      <= 1'b0;
         bootPending <= 1'b1;
      end else if (launch) begin
         pcReg       <= nextPc;
         bootPending <= 1'b0;
         if (nextPc[1:0] != 2'b00) begin
            instReg <= '0;
            errReg  <= 1'b1;
            state   <= HOLD;
         end else begin
            state   <= ADDR;
         end
      end else begin
         case (state)
            ADDR: begin
               if (arready) state <= DATA;
            end
            DATA: begin
               if (rvalid) begin
                  instReg <= rdata;
                  errReg  <= (rresp != 2'b00);
                  state   <= HOLD;
               end
            end
            HOLD: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef IFU_PERF_CNT_EN
   logic [31:0] fetchCnt;
   assign fetch_cnt = fetchCnt;

   // Count instructions accepted by decode; the counter wraps naturally.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetchCnt <= '0;
      end else if (handshake) begin
         fetchCnt <= fetchCnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_ifu_axi_fetch.sv
// tb_ifu_axi_fetch: randomized scoreboard bench for ifu_axi_fetch.
// A driver issues fetch requests and pushes the predicted decode-side result.
// A memory-backed AXI slave answers reads, and a monitor pops and compares
// each presented instruction.
module tb_ifu_axi_fetch;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        err;
   } expT;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic [31:0] req_pc;
   logic        arvalid;
   logic [31:0] araddr;
   logic        arready;
   logic        rvalid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rready;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_inst;
   logic [31:0] out_pc;
   logic        out_err;
`ifdef IFU_PERF_CNT_EN
   logic [31:0] fetch_cnt;
   logic [31:0] hsModel;
   logic        cntCheckDue;
`endif

   int          checkCount;
   int          passCount;
   int          outstanding;
   bit          allowIssue;
   bit          slaveFast;
   int          stallPlan;
   int          handshakes;
   expT         expQ[$];
   logic [31:0] addrQ[$];
   logic [31:0] pcPlan[$];

   ifu_axi_fetch #(.ADDR_W(32), .RESET_PC(32'h8000_0000)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_pc    (req_pc),
      .arvalid   (arvalid),
      .araddr    (araddr),
      .arready   (arready),
      .rvalid    (rvalid),
      .rdata     (rdata),
      .rresp     (rresp),
      .rready    (rready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_inst  (out_inst),
      .out_pc    (out_pc),
`ifdef IFU_PERF_CNT_EN
      .fetch_cnt (fetch_cnt),
`endif
      .out_err   (out_err)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory image seen by the slave: fixed boot word, address-derived data.
   function automatic logic [31:0] memData(input logic [31:0] a);
      if (a == 32'h8000_0000) return 32'h0000_0413;
      return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
   endfunction

   // Slave response code per address: some lines fault.
   function automatic logic [1:0] memResp(input logic [31:0] a);
      if (a[7:4] == 4'h1) return 2'b10;
      if (a[7:4] == 4'h5) return 2'b01;
      return 2'b00;
   endfunction

   // What decode should see for a fetch of pc.
   function automatic expT predict(input logic [31:0] pc);
      expT e;
      e.pc = pc;
      if (pc[1:0] != 2'b00) begin
         e.inst = 32'h0;
         e.err  = 1'b1;
      end else begin
         e.inst = memData(pc);
         e.err  = (memResp(pc) != 2'b00);
      end
      return e;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
   endtask

   task automatic flagFail(input string name);
      checkCount++;
      $display("[TB] FAIL %s (t=%0t)", name, $time);
   endtask

   // Issue one fetch request and record what must come out for it.
   task automatic applyStimulus(input logic [31:0] pc);
      req_valid = 1'b1;
      req_pc    = pc;
      expQ.push_back(predict(pc));
      if (pc[1:0] == 2'b00) addrQ.push_back(pc);
      outstanding = 1;
   endtask

   function automatic logic [31:0] randomPc();
      logic [31:0] p;
      p = 32'h8000_0000 + 32'($urandom_range(0, 255)) * 32'd4;
      if ($urandom_range(0, 7) == 0) p = p + 32'($urandom_range(1, 3));
      return p;
   endfunction

   // Request driver: a real request when nothing is outstanding, junk
   // requests (which must be ignored) while a fetch is in flight.
   initial begin
      req_valid = 1'b0;
      req_pc    = '0;
      forever begin
         @(posedge clk);
         #2;
         req_valid = 1'b0;
         req_pc    = $urandom;
         if (rst) begin
            if (outstanding == 0 && allowIssue &&
                (pcPlan.size() > 0 || $urandom_range(0, 3) != 0)) begin
               if (pcPlan.size() > 0) applyStimulus(pcPlan.pop_front());
               else applyStimulus(randomPc());
            end else if (outstanding != 0 && $urandom_range(0, 2) == 0) begin
               req_valid = 1'b1;
            end
         end
      end
   end

   // AXI-lite slave: checks each address against the expected bus traffic,
   // answers with random delays, and sprinkles stray rvalid during the
   // address phase.
   initial begin
      logic [31:0] pendAddr;
      bit          pending;
      int          arWait;
      int          rWait;
      pending = 0;
      arWait  = -1;
      rWait   = 0;
      arready = 1'b0;
      rvalid  = 1'b0;
      rdata   = '0;
      rresp   = '0;
      forever begin
         @(posedge clk);
         #1;
         arready = 1'b0;
         rvalid  = 1'b0;
         rdata   = $urandom;
         rresp   = 2'($urandom);
         if (!rst) begin
            pending = 0;
            arWait  = -1;
         end else if (pending) begin
            checkOutput("rreadyInData", {63'd0, rready}, 64'd1);
            if (rWait == 0) begin
               rvalid  = 1'b1;
               rdata   = memData(pendAddr);
               rresp   = memResp(pendAddr);
               pending = 0;
            end else begin
               rWait--;
            end
         end else begin
            checkOutput("rreadyIdle", {63'd0, rready}, 64'd0);
            if (arvalid) begin
               if (addrQ.size() == 0) flagFail("unexpectedArvalid");
               else checkOutput("araddr", {32'd0, araddr}, {32'd0, addrQ[0]});
               if (arWait < 0) arWait = slaveFast ? 0 : $urandom_range(0, 3);
               if (arWait == 0) begin
                  arready  = 1'b1;
                  pendAddr = araddr;
                  pending  = 1;
                  rWait    = slaveFast ? 0 : $urandom_range(0, 3);
                  arWait   = -1;
                  if (addrQ.size() > 0) void'(addrQ.pop_front());
               end else begin
                  arWait--;
               end
               if ($urandom_range(0, 2) == 0) rvalid = 1'b1;
            end
         end
      end
   end

   // Decode-side monitor: applies backpressure, checks held outputs against
   // the scoreboard head, and pops it on each handshake.
   initial begin
      int  stallLeft;
      int  waitCnt;
      expT e;
      stallLeft = -1;
      waitCnt   = 0;
      out_ready = 1'b0;
`ifdef IFU_PERF_CNT_EN
      cntCheckDue = 1'b0;
`endif
      forever begin
         @(posedge clk);
         #1;
         if (!rst) begin
            out_ready = 1'b0;
            stallLeft = -1;
            waitCnt   = 0;
`ifdef IFU_PERF_CNT_EN
            cntCheckDue = 1'b0;
`endif
         end else begin
`ifdef IFU_PERF_CNT_EN
            if (cntCheckDue) begin
               checkOutput("fetchCnt", {32'd0, fetch_cnt}, {32'd0, hsModel});
               cntCheckDue = 1'b0;
            end
`endif
            if (out_valid) begin
               waitCnt = 0;
               if (expQ.size() == 0) begin
                  flagFail("unexpectedOutValid");
                  out_ready = 1'b1;
               end else begin
                  e = expQ[0];
                  if (stallLeft < 0) begin
                     if (stallPlan >= 0) begin
                        stallLeft = stallPlan;
                        stallPlan = -1;
                     end else begin
                        stallLeft = $urandom_range(0, 2);
                     end
                  end
                  checkOutput("outPc",   {32'd0, out_pc},   {32'd0, e.pc});
                  checkOutput("outInst", {32'd0, out_inst}, {32'd0, e.inst});
                  checkOutput("outErr",  {63'd0, out_err},  {63'd0, e.err});
                  if (stallLeft > 0) begin
                     out_ready = 1'b0;
                     stallLeft--;
                  end else begin
                     out_ready = 1'b1;
                     void'(expQ.pop_front());
                     outstanding = 0;
                     handshakes++;
                     stallLeft = -1;
`ifdef IFU_PERF_CNT_EN
                     hsModel     = hsModel + 32'd1;
                     cntCheckDue = 1'b1;
`endif
                  end
               end
            end else begin
               out_ready = 1'($urandom_range(0, 1));
               if (stallLeft >= 0) begin
                  flagFail("outValidDroppedWhileHeld");
                  stallLeft = -1;
               end
               if (outstanding != 0) begin
                  waitCnt++;
                  if (waitCnt > 100) begin
                     flagFail("fetchTimeout");
                     waitCnt = 0;
                  end
               end
            end
         end
      end
   end

   // Director: reset state, boot fetch, directed corner PCs, random traffic,
   // reset in the middle of a fetch, then drain.
   initial begin
      bit found;
      checkCount  = 0;
      passCount   = 0;
      outstanding = 0;
      handshakes  = 0;
      allowIssue  = 0;
      slaveFast   = 1;
      stallPlan   = 5;
      rst         = 1'b0;
`ifdef IFU_PERF_CNT_EN
      hsModel = '0;
`endif
      repeat (3) @(posedge clk);
      #1;
      checkOutput("resetArvalid",  {63'd0, arvalid},   64'd0);
      checkOutput("resetRready",   {63'd0, rready},    64'd0);
      checkOutput("resetOutValid", {63'd0, out_valid}, 64'd0);
      checkOutput("resetOutInst",  {32'd0, out_inst},  64'd0);
      checkOutput("resetOutPc",    {32'd0, out_pc},    64'h8000_0000);
      checkOutput("resetOutErr",   {63'd0, out_err},   64'd0);

      @(negedge clk);
      expQ.push_back(predict(32'h8000_0000));
      addrQ.push_back(32'h8000_0000);
      outstanding = 1;
      rst = 1'b1;
      pcPlan.push_back(32'h8000_0010);
      pcPlan.push_back(32'h8000_0002);
      pcPlan.push_back(32'h8000_0004);
      allowIssue = 1;
      for (int i = 0; i < 100 && handshakes < 1; i++) @(posedge clk);
      if (handshakes < 1) flagFail("bootNeverDelivered");
      slaveFast = 0;

      repeat (800) @(posedge clk);

      found = 0;
      for (int i = 0; i < 300 && !found; i++) begin
         @(posedge clk);
         #3;
         if (rready) found = 1;
      end
      checkOutput("midFetchReached", {63'd0, found}, 64'd1);
      rst = 1'b0;
      expQ.delete();
      addrQ.delete();
      outstanding = 0;
`ifdef IFU_PERF_CNT_EN
      hsModel = '0;
`endif
      #1;
      checkOutput("asyncArvalid",  {63'd0, arvalid},   64'd0);
      checkOutput("asyncRready",   {63'd0, rready},    64'd0);
      checkOutput("asyncOutValid", {63'd0, out_valid}, 64'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      expQ.push_back(predict(32'h8000_0000));
      addrQ.push_back(32'h8000_0000);
      outstanding = 1;
      rst = 1'b1;

      repeat (400) @(posedge clk);
      allowIssue = 0;
      for (int i = 0; i < 300 && outstanding != 0; i++) @(posedge clk);
      if (outstanding != 0) flagFail("drainTimeout");

`ifdef IFU_PERF_CNT_EN
      repeat (3) @(posedge clk);
      @(negedge clk);
      dut.fetchCnt = 32'hFFFF_FFFF;
      hsModel      = 32'hFFFF_FFFF;
      pcPlan.push_back(32'h8000_0020);
      allowIssue = 1;
      @(posedge clk);
      #3;
      allowIssue = 0;
      for (int i = 0; i < 300 && outstanding != 0; i++) @(posedge clk);
      if (outstanding != 0) flagFail("wrapDrainTimeout");
      repeat (2) @(posedge clk);
`endif

      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/ifu_axi_fetch.md
IFU_AXI_FETCH -- requirements
Module: ifu_axi_fetch

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning fetch address width.
REQ-002 SHALL have parameter RESET_PC, default 32'h8000_0000, meaning the PC that is fetched automatically after reset release.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, meaning asynchronous, active-low reset.
REQ-005 SHALL have port req_valid, input, 1, meaning a next-PC fetch request from the writeback/PC logic.
REQ-006 SHALL have port req_pc, input, ADDR_W, meaning the PC to fetch.
REQ-007 SHALL have port arvalid, output, 1, meaning AXI-lite read address valid.
REQ-008 SHALL have port araddr, output, ADDR_W, meaning the read address (equals the latched PC).
REQ-009 SHALL have port arready, input, 1, meaning the slave accepts the address.
REQ-010 SHALL have port rvalid, input, 1, meaning read data valid.
REQ-011 SHALL have port rdata, input, 32, meaning read data.
REQ-012 SHALL have port rresp, input, 2, meaning the read response code.
REQ-013 SHALL have port rready, output, 1, meaning the fetch unit can accept read data.
REQ-014 SHALL have port out_valid, output, 1, meaning inst/pc are valid toward the decode stage bus.
REQ-015 SHALL have port out_ready, input, 1, meaning the decode stage bus accepts.
REQ-016 SHALL have port out_inst, output, 32, meaning the fetched instruction.
REQ-017 SHALL have port out_pc, output, ADDR_W, meaning the PC of out_inst.
REQ-018 SHALL have port out_err, output, 1, meaning a fetch fault accompanies out_inst.

Function
REQ-019 SHALL implement FSM states IDLE, ADDR, DATA, HOLD; one fetch outstanding at most.
REQ-020 SHALL move IDLE->ADDR on the first clk edge after reset release and latch RESET_PC without a req_valid.
REQ-021 SHALL, in IDLE, latch req_pc when req_valid=1 and move to ADDR; req_valid in any other state SHALL be ignored.
REQ-022 SHALL move IDLE->HOLD directly with out_inst=0, out_err=1 and no bus access when the latched PC has bits [1:0] != 0.
REQ-023 SHALL drive arvalid=1 only in ADDR, holding araddr stable until arready; ADDR->DATA on arvalid&arready.
REQ-024 SHALL drive rready=1 only in DATA; on rvalid, latch rdata into out_inst, set out_err=(rresp!=0), and move to HOLD.
REQ-025 SHALL drive out_valid=1 only in HOLD, with out_inst/out_pc/out_err stable until out_ready.
REQ-026 SHALL move HOLD->IDLE on out_valid&out_ready; when req_valid is also high in that cycle, HOLD SHALL go directly to ADDR with req_pc latched.
REQ-027 SHALL have minimum latency req_valid->out_valid of 3 cycles (arready and rvalid same-cycle responsive).
REQ-028 SHALL tolerate rvalid asserted while in ADDR by ignoring it (rready=0).

Reset
REQ-029 SHALL, while rst=0, force state=IDLE, arvalid=0, rready=0, out_valid=0, out_inst=0, out_pc=RESET_PC, out_err=0, and the pending-boot flag set, asynchronously.
REQ-030 SHALL, on reset asserted mid-transaction, abandon the transaction; after release, behave per REQ-020.

Configuration
REQ-031 SHALL, when IFU_PERF_CNT_EN is defined, add output fetch_cnt (32 bits, reset 0), which increments by 1 on each out_valid&out_ready and wraps from 0xFFFF_FFFF to 0.
REQ-032 SHALL, when IFU_PERF_CNT_EN is undefined, have no fetch_cnt port and no counter logic; all other behaviour is identical.

Verification
REQ-033 SHALL cover boot: release rst, slave returns rdata=32'h0000_0413 immediately -> araddr=32'h8000_0000; out_valid with out_inst=32'h0000_0413, out_pc=32'h8000_0000, out_err=0.
REQ-034 SHALL cover backpressure: out_ready=0 for 5 cycles -> out_valid stays 1 and out_inst/out_pc are unchanged; no new arvalid.
REQ-035 SHALL cover a slave error: rresp=2'b10 for pc 32'h8000_0010 -> out_err=1, out_pc=32'h8000_0010.
REQ-036 SHALL cover misalignment: req_pc=32'h8000_0002 -> arvalid never asserted; out_valid with out_inst=0, out_err=1.
REQ-037 SHALL cover reset mid-fetch: rst=0 while in DATA -> arvalid, rready, and out_valid drop to 0 asynchronously; after release, the next araddr=32'h8000_0000.
REQ-038 SHALL cover the counter: with IFU_PERF_CNT_EN, 3 accepted handshakes -> fetch_cnt=3; with the counter preset to 0xFFFF_FFFF, one more handshake -> 0.
